mem_stage: RTL and testbench

Memory-access stage of the 16-bit five-stage pipeline, between the EX/MEM pipeline register and writeback. Resolves branches and jumps, and drives a variable-latency data-memory request/ready handshake, stalling the upstream pipeline while a request is outstanding. Registers its results as the MEM/WB boundary, tracks the sticky halt state and counts memory stall cycles.

---
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit five-stage pipeline.
//   Resolves branches and jumps. Issues data-memory requests and waits for
//   dmem_ready, holding the upstream stages with stall while a request is
//   outstanding. Registers the MEM/WB boundary, keeps a sticky halt flag and
//   counts stall cycles with saturation.
// Optional feature: define MEM_ALIGN_CHK_EN to trap odd-address memory ops.
//   A trapped op issues no request; when it is accepted it sets align_err and
//   halts the stage. Without the macro, align_err is 0 and odd addresses go to
//   memory unchanged.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_in, *_in            EX/MEM pipeline register contents
//   dmem_req/we/addr/wdata    memory request (combinational)
//   dmem_rdata, dmem_ready    memory response
//   stall                     hold EX/MEM and all earlier stages
//   redirect, redirect_pc     fetch redirect (combinational)
//   wb_*                      MEM/WB pipeline register
//   halted, stall_cycles, align_err  status
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] branch_result_in,
  input  logic [15:0] jumpaddr_in,
  input  logic [15:0] next_pc_in,
  input  logic [15:0] read2data_in,
  input  logic        zero_in,
  input  logic        ltz_in,
  input  logic [4:0]  alu_op_in,
  input  logic [2:0]  write_reg_in,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        halt_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic        wb_halt,
  output logic [15:0] wb_alu_result,
  output logic [15:0] wb_mem_data,
  output logic [15:0] wb_next_pc,
  output logic [2:0]  wb_write_reg,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic        align_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  state_e state_q, state_d;

  logic        halted_q, halted_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, wb_halt_q;
  logic [15:0] wb_alu_result_q, wb_mem_data_q, wb_next_pc_q;
  logic [2:0]  wb_write_reg_q;

  logic live, mem_op, misalign, req_op, taken, accept;

  // Halted stage ignores everything EX/MEM presents.
  assign live   = valid_in & ~halted_q;
  assign mem_op = live & (mem_read_in | mem_write_in);
`ifdef MEM_ALIGN_CHK_EN
  assign misalign = mem_op & alu_result_in[0];
`else
  assign misalign = 1'b0;
`endif
  // Only aligned (or unchecked) ops actually reach memory.
  assign req_op = mem_op & ~misalign;

  always_comb begin
    case (alu_op_in[1:0])
      2'b00:   taken = zero_in;
      2'b01:   taken = ~zero_in;
      2'b10:   taken = ltz_in;
      default: taken = ~ltz_in;
    endcase
  end

  assign redirect    = ~rst & live & (jump_in | (branch_in & taken));
  assign redirect_pc = jump_in ? jumpaddr_in : branch_result_in;
  assign dmem_addr   = alu_result_in;
  assign dmem_wdata  = read2data_in;
  assign dmem_we     = dmem_req & mem_write_in;
  assign accept      = live & ~stall;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_op & ~dmem_ready) state_d = WAIT;
      WAIT: if (dmem_ready | ~req_op) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (suppressed during reset so a dropped WAIT request ends now)
  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: if (req_op) begin
          dmem_req = 1'b1;
          stall    = ~dmem_ready;
        end
        WAIT: begin
          dmem_req = req_op;
          stall    = req_op & ~dmem_ready;
        end
        default: ;
      endcase
    end
  end

  assign halted_d       = halted_q | (accept & (halt_in | misalign));
  assign stall_cycles_d = (stall && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1
                                                                : stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q        <= 1'b0;
      stall_cycles_q  <= 16'h0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_halt_q       <= 1'b0;
      wb_alu_result_q <= 16'h0;
      wb_mem_data_q   <= 16'h0;
      wb_next_pc_q    <= 16'h0;
      wb_write_reg_q  <= 3'h0;
    end else begin
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
      wb_valid_q     <= accept;
      wb_reg_write_q <= accept & reg_write_in & ~misalign;
      if (accept) begin
        wb_mem_to_reg_q <= mem_to_reg_in;
        wb_halt_q       <= halt_in | misalign;
        wb_alu_result_q <= alu_result_in;
        wb_mem_data_q   <= (req_op & mem_read_in) ? dmem_rdata : 16'h0;
        wb_next_pc_q    <= next_pc_in;
        wb_write_reg_q  <= write_reg_in;
      end
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  logic align_err_q;
  always_ff @(posedge clk) begin
    if (rst)                      align_err_q <= 1'b0;
    else if (accept & misalign)   align_err_q <= 1'b1;
  end
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  assign halted        = halted_q;
  assign stall_cycles  = stall_cycles_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_halt       = wb_halt_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign wb_next_pc    = wb_next_pc_q;
  assign wb_write_reg  = wb_write_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_result_in, branch_result_in, jumpaddr_in, next_pc_in, read2data_in;
  logic        zero_in, ltz_in;
  logic [4:0]  alu_op_in;
  logic [2:0]  write_reg_in;
  logic        branch_in, jump_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, halt_in;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready, stall, redirect;
  logic [15:0] redirect_pc;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_halt;
  logic [15:0] wb_alu_result, wb_mem_data, wb_next_pc;
  logic [2:0]  wb_write_reg;
  logic        halted;
  logic [15:0] stall_cycles;
  logic        align_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .branch_result_in(branch_result_in),
    .jumpaddr_in(jumpaddr_in), .next_pc_in(next_pc_in), .read2data_in(read2data_in),
    .zero_in(zero_in), .ltz_in(ltz_in), .alu_op_in(alu_op_in), .write_reg_in(write_reg_in),
    .branch_in(branch_in), .jump_in(jump_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .halt_in(halt_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_halt(wb_halt), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_next_pc(wb_next_pc), .wb_write_reg(wb_write_reg), .halted(halted),
    .stall_cycles(stall_cycles), .align_err(align_err)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic        zero, ltz, br, jmp, rd, wr, rw, m2r, rdy;
    logic [15:0] addr, wdata, bres, jaddr, rdata;
    logic        e_req, e_we, e_stall, e_redir;
    logic [15:0] e_rpc;
    logic        e_wbv, e_wbrw;
    logic [15:0] e_md;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    valid_in = 0; alu_result_in = 0; branch_result_in = 0; jumpaddr_in = 0;
    next_pc_in = 0; read2data_in = 0; zero_in = 0; ltz_in = 0; alu_op_in = 0;
    write_reg_in = 0; branch_in = 0; jump_in = 0; mem_read_in = 0; mem_write_in = 0;
    mem_to_reg_in = 0; reg_write_in = 0; halt_in = 0; dmem_rdata = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_in(); rst = 1;
    @(posedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic load(input logic [15:0] a, input logic rdy, input logic [15:0] rdat);
    idle_in();
    valid_in = 1; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
    write_reg_in = 3'd5; alu_result_in = a; dmem_ready = rdy; dmem_rdata = rdat;
  endtask

  vec_t vt[11];

  initial begin
    // valid op zr lz br jp rd wr rw m2r rdy addr wdata bres jaddr rdata | req we st rd rpc wbv wbrw md
    vt[0]  = '{0,2'd0,0,0,0,0,0,0,0,0,0,16'h0000,16'h0000,16'h0040,16'h0000,16'h0000, 0,0,0,0,16'h0040,0,0,16'h0000};
    vt[1]  = '{1,2'd0,0,0,0,0,0,0,1,0,0,16'h00A5,16'h0000,16'h0050,16'h0000,16'h0000, 0,0,0,0,16'h0050,1,1,16'h0000};
    vt[2]  = '{1,2'd2,0,1,1,0,0,0,0,0,0,16'h0000,16'h0000,16'h0040,16'h0000,16'h0000, 0,0,0,1,16'h0040,1,0,16'h0000};
    vt[3]  = '{1,2'd2,0,0,1,0,0,0,0,0,0,16'h0000,16'h0000,16'h0040,16'h0000,16'h0000, 0,0,0,0,16'h0040,1,0,16'h0000};
    vt[4]  = '{1,2'd0,1,0,1,0,0,0,0,0,0,16'h0000,16'h0000,16'h0060,16'h0000,16'h0000, 0,0,0,1,16'h0060,1,0,16'h0000};
    vt[5]  = '{1,2'd1,1,0,1,0,0,0,0,0,0,16'h0000,16'h0000,16'h0060,16'h0000,16'h0000, 0,0,0,0,16'h0060,1,0,16'h0000};
    vt[6]  = '{1,2'd3,0,0,1,0,0,0,0,0,0,16'h0000,16'h0000,16'h0070,16'h0000,16'h0000, 0,0,0,1,16'h0070,1,0,16'h0000};
    vt[7]  = '{1,2'd1,1,0,1,1,0,0,0,0,0,16'h0000,16'h0000,16'h0040,16'h0100,16'h0000, 0,0,0,1,16'h0100,1,0,16'h0000};
    vt[8]  = '{1,2'd0,0,0,0,0,0,1,0,0,1,16'h0020,16'h1234,16'h0000,16'h0000,16'h0000, 1,1,0,0,16'h0000,1,0,16'h0000};
    vt[9]  = '{1,2'd0,0,0,0,0,1,0,1,1,1,16'h0030,16'h0000,16'h0000,16'h0000,16'h5555, 1,0,0,0,16'h0000,1,1,16'h5555};
    vt[10] = '{1,2'd0,0,0,0,0,0,0,1,0,1,16'h0044,16'h0000,16'h0000,16'h0000,16'h7777, 0,0,0,0,16'h0000,1,1,16'h0000};

    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    // Reset state, with a load presented: outputs must stay quiet while rst is high.
    @(negedge clk); load(16'h0010, 1'b0, 16'h0); #1;
    chk("rst_comb", {dmem_req, stall, redirect}, 3'b000);
    idle_in();
    @(posedge clk); @(negedge clk); rst = 0; #1;
    chk("rst_state", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_halt, halted, align_err, stall_cycles},
        {6'b0, 16'h0});
    chk("rst_wbdata", {wb_alu_result, wb_mem_data, wb_next_pc, 13'h0, wb_write_reg}, 64'h0);

    // Load with 3 wait cycles.
    load(16'h0010, 1'b0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("wait_stall%0d", c), {dmem_req, dmem_we, stall}, 3'b101);
      @(posedge clk); @(negedge clk);
    end
    dmem_ready = 1; dmem_rdata = 16'hBEEF; #1;
    chk("wait_done", {dmem_req, stall}, 2'b10);
    @(posedge clk); #1;
    chk("wait_wb", {wb_valid, wb_mem_to_reg, wb_mem_data}, {2'b11, 16'hBEEF});
    chk("wait_cnt", stall_cycles, 16'd3);

    // Table of single-cycle vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_in();
      valid_in = vt[i].valid; alu_op_in = {3'b000, vt[i].op}; zero_in = vt[i].zero;
      ltz_in = vt[i].ltz; branch_in = vt[i].br; jump_in = vt[i].jmp;
      mem_read_in = vt[i].rd; mem_write_in = vt[i].wr; reg_write_in = vt[i].rw;
      mem_to_reg_in = vt[i].m2r; dmem_ready = vt[i].rdy; alu_result_in = vt[i].addr;
      read2data_in = vt[i].wdata; branch_result_in = vt[i].bres; jumpaddr_in = vt[i].jaddr;
      dmem_rdata = vt[i].rdata; next_pc_in = 16'h0100 + 16'(i);
      #1;
      chk($sformatf("v%0d_comb", i), {dmem_req, dmem_we, stall, redirect, redirect_pc},
          {vt[i].e_req, vt[i].e_we, vt[i].e_stall, vt[i].e_redir, vt[i].e_rpc});
      chk($sformatf("v%0d_dmem", i), {dmem_addr, dmem_wdata}, {vt[i].addr, vt[i].wdata});
      @(posedge clk); #1;
      chk($sformatf("v%0d_wbctl", i), {wb_valid, wb_reg_write}, {vt[i].e_wbv, vt[i].e_wbrw});
      if (vt[i].e_wbv)
        chk($sformatf("v%0d_wbdat", i), {wb_mem_data, wb_alu_result, wb_next_pc, 15'h0, wb_mem_to_reg},
            {vt[i].e_md, vt[i].addr, 16'h0100 + 16'(i), 15'h0, vt[i].m2r});
    end
    chk("tbl_nostall_cnt", stall_cycles, 16'd3);

    // Reset while in WAIT.
    @(negedge clk); load(16'h0010, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; idle_in(); #1;
    chk("rstwait_comb", {dmem_req, stall}, 2'b00);
    chk("rstwait_state", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_halt, halted, stall_cycles},
        {5'b0, 16'h0});
    chk("rstwait_wbdata", {wb_alu_result, wb_mem_data, wb_next_pc}, 48'h0);
    // Back in IDLE: a zero-wait load completes with no stall.
    load(16'h0022, 1'b1, 16'h0A0A); #1;
    chk("rstwait_idle", {dmem_req, stall}, 2'b10);
    @(posedge clk); #1;
    chk("rstwait_ld", {wb_valid, wb_mem_data}, {1'b1, 16'h0A0A});

    // Halt, then a load and a jump are ignored.
    @(negedge clk); idle_in(); valid_in = 1; halt_in = 1; reg_write_in = 1;
    @(posedge clk); #1;
    chk("halt_acc", {halted, wb_halt, wb_valid}, 3'b111);
    @(negedge clk); load(16'h0010, 1'b1, 16'h1111); jump_in = 1; jumpaddr_in = 16'h0200; #1;
    chk("halt_ign", {dmem_req, stall, redirect}, 3'b000);
    @(posedge clk); #1;
    chk("halt_wbv1", {wb_valid, wb_reg_write, halted}, 3'b001);
    @(posedge clk); #1;
    chk("halt_wbv2", {wb_valid, halted}, 2'b01);
    do_reset();

    // Odd address.
    load(16'h0013, 1'b0, 16'h0); #1;
`ifdef MEM_ALIGN_CHK_EN
    chk("align_comb", {dmem_req, stall}, 2'b00);
    @(posedge clk); #1;
    chk("align_wb", {align_err, halted, wb_valid, wb_reg_write, wb_halt}, 5'b11101);
`else
    chk("odd_comb", {dmem_req, stall, dmem_addr}, {2'b11, 16'h0013});
    @(negedge clk); dmem_ready = 1; dmem_rdata = 16'h4242;
    @(posedge clk); #1;
    chk("odd_wb", {align_err, halted, wb_valid, wb_reg_write, wb_mem_data}, {4'b0011, 16'h4242});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
